// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares a single-ported memory interface between the instruction fetch
//   requester (PC stage) and the data requester (MEM stage). Data has fixed
//   priority, but after STARVE_LIMIT consecutive data grants that left a fetch
//   waiting, the fetch wins once. One command is outstanding at a time. The
//   memory may take any number of cycles to ack. A branch redirect (inst_flush)
//   drops the response of an in-flight fetch.
//
// Ports
//   clk, rst                 clock (posedge) / synchronous active-low reset
//   inst_req/addr            fetch request, held until inst_ready
//   inst_flush               discard the response of the in-flight fetch
//   inst_ready               fetch accepted this cycle (combinational)
//   inst_rvalid/rdata        one-cycle fetch response
//   data_req/we/addr/wdata   data request, held until data_ready
//   data_ready               data accepted this cycle (combinational)
//   data_rvalid/rdata        one-cycle load/store completion (rdata 0 for stores)
//   mem_en/we/addr/wdata     memory command, held until mem_ack
//   mem_rdata, mem_ack       memory response
module imem_dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_flush,
  output logic                  inst_ready,
  output logic                  inst_rvalid,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_req,
  input  logic [3:0]            data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ready,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            flushed_q, flushed_d;
  logic            grant_inst, grant_data;
  logic            inst_drop;

  // Arbitration and next state. Grants are gated by rst so that no ready
  // escapes during a reset cycle.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    state_d    = state_q;
    starve_d   = starve_q;
    flushed_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rst) begin
          if (inst_req && data_req) begin
            if (starve_q == STARVE_MAX) grant_inst = 1'b1;
            else                        grant_data = 1'b1;
          end else if (inst_req) begin
            grant_inst = 1'b1;
          end else if (data_req) begin
            grant_data = 1'b1;
          end
        end
        if (grant_inst) begin
          state_d  = INST;
          starve_d = '0;
        end else if (grant_data) begin
          state_d = DATA;
          if (inst_req && (starve_q != STARVE_MAX)) starve_d = starve_q + CW'(1);
        end
      end
      INST: begin
        // Remember a redirect seen at any point while the fetch is in flight.
        flushed_d = flushed_q | inst_flush;
        if (mem_ack) state_d = IDLE;
      end
      DATA: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_ready = grant_inst;
  assign data_ready = grant_data;
  // A flush in the ack cycle itself also drops the response.
  assign inst_drop  = flushed_q | inst_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      flushed_q   <= 1'b0;
      inst_rvalid <= 1'b0;
      inst_rdata  <= '0;
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      flushed_q   <= flushed_d;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (grant_inst) begin
            mem_en    <= 1'b1;
            mem_we    <= '0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
          end else if (grant_data) begin
            mem_en    <= 1'b1;
            mem_we    <= data_we;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
          end
        end
        INST: begin
          if (mem_ack) begin
            mem_en <= 1'b0;
            if (!inst_drop) begin
              inst_rvalid <= 1'b1;
              inst_rdata  <= mem_rdata;
            end
          end
        end
        DATA: begin
          if (mem_ack) begin
            mem_en      <= 1'b0;
            data_rvalid <= 1'b1;
            data_rdata  <= (mem_we == '0) ? mem_rdata : '0;
          end
        end
        default: mem_en <= 1'b0;
      endcase
    end
  end

endmodule
